ysyx_22041071_axi_w_arb: RTL and testbench
==========================================

YSYX_22041071_AXI_W_ARB -- requirements
Module: ysyx_22041071_axi_w_arb

Interface
REQ-001 SHALL have parameters (name, default, meaning): ID_W, 4, transaction ID width; ADDR_W, 64, address width; LEN_W, 8, burst-length width; DATA_W, 64, write-data width; RESP_W, 2, write-response width; TMO, 1024, wait-watchdog limit in cycles.
REQ-002 SHALL have one clock and a synchronous, active-low reset: `clk` (in, 1, rising-edge clock) and `reset_n` (in, 1, synchronous active-low reset).
REQ-003 SHALL provide requester port r (r = 0, 1): `req_valid_r` (in, 1, write request).
REQ-004 SHALL provide `req_id_r` (in, ID_W), `req_addr_r` (in, ADDR_W), `req_len_r` (in, LEN_W), `req_size_r` (in, 2, 00=1B..11=8B) and `req_wdata_r` (in, DATA_W).
REQ-005 SHALL provide `req_done_r` (out, 1, completion pulse) and `req_resp_r` (out, RESP_W, B response).
REQ-006 SHALL provide master-side outputs to the AXI write engine: `m_aw_valid` (out, 1), `m_id` (out, ID_W), `m_addr` (out, ADDR_W), `m_len` (out, LEN_W), `m_size` (out, 2) and `m_wdata` (out, DATA_W).
REQ-007 SHALL provide master-side inputs `m_aw_ready` (in, 1, engine idle) and `m_w_resp` (in, RESP_W, registered B response).
REQ-008 SHALL provide status outputs `grant` (out, 1, index of the current owner), `busy` (out, 1, state != IDLE) and `tmo_err` (out, 1, sticky watchdog flag).

Function
REQ-009 SHALL implement a state machine with states IDLE, ISSUE, WAIT and DONE.
REQ-010 IDLE: SHALL arbitrate only when `m_aw_ready`=1 and at least one `req_valid` is high, then load `grant` and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-011 Arbitration SHALL be round-robin:
- single requester active -> that requester wins;
- both active -> the requester not granted last wins;
- the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-012 ISSUE: SHALL drive `m_aw_valid`=1 with the m_* fields muxed combinationally from the granted requester; SHALL go to WAIT on the first cycle `m_aw_ready`=0.
REQ-013 WAIT: SHALL drive `m_aw_valid`=0, keep the m_* fields muxed from the owner, and go to DONE on the first cycle `m_aw_ready`=1.
REQ-014 DONE: SHALL assert `req_done[grant]`=1 for exactly one cycle with `req_resp[grant]` = `m_w_resp` captured on the WAIT->DONE edge, update the last-grant pointer, and return to IDLE.
REQ-015 The non-granted `req_done` SHALL stay 0; the `req_resp` outputs SHALL hold their last value until the next completion.
REQ-016 A requester SHALL hold its fields stable from `req_valid` until `req_done`; a `req_valid` drop after grant SHALL NOT abort the transaction, which completes and pulses done.
REQ-017 A requester still valid in the cycle after DONE SHALL be re-arbitrated as a new request; the minimum gap between consecutive grants is one IDLE cycle.
REQ-018 Latency: grant to `m_aw_valid` 1 cycle; `m_aw_ready` rise to `req_done` 1 cycle.
REQ-019 Watchdog: the counter SHALL clear on entering ISSUE and increment each ISSUE/WAIT cycle, saturating at TMO.
REQ-020 At TMO the watchdog SHALL set `tmo_err` (sticky until reset) and the FSM SHALL continue waiting with no abort.
REQ-021 Requests arriving in ISSUE/WAIT/DONE SHALL be ignored until IDLE; `m_aw_ready`=0 in IDLE SHALL block grant.

Reset
REQ-022 On `reset_n`=0 at a clock edge the block SHALL:
- set state to IDLE, `grant`=0, last-grant pointer =1;
- clear `m_aw_valid`, all `req_done`, `req_resp`=0, `tmo_err`=0, `busy`=0 and the watchdog;
- zero the m_* fields.
REQ-023 Reset mid-transaction SHALL abandon the transaction with no done pulse.

Verification
REQ-024 Req0 only, addr 0x8000_0010, size 10; engine ready drops 1 cycle after valid, rises 6 cycles later with resp 00 -> `m_aw_valid` high exactly 2 cycles; `req_done_0` is a 1-cycle pulse, resp 00; `req_done_1` stays 0.
REQ-025 Both requesters valid from reset, each held until its done -> grant order 0,1,0,1 across 4 transactions, each done matching its own ID.
REQ-026 Req1 valid while req0 is in WAIT -> no m_* change during WAIT; req1 granted in the IDLE cycle after req0 done.
REQ-027 Engine never returns ready (TMO=16) -> `tmo_err`=1 after 16 busy cycles; `busy` stays 1 with no done pulse.
REQ-028 `reset_n` low during WAIT -> next cycle IDLE, all outputs 0, no `req_done`; a tie after reset grants req0.
REQ-029 Engine returns resp 10 (SLVERR) for req1 -> `req_resp_1`=10 with the done pulse; `req_resp_0` is unchanged.

Source files
------------

// File: rtl/ysyx_22041071_axi_w_arb.sv
// Two-requester round-robin arbiter in front of a single AXI write engine.
// One transaction runs at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
module ysyx_22041071_axi_w_arb #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 8,
    parameter int DATA_W = 64,
    parameter int RESP_W = 2,
    parameter int TMO    = 1024
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req_valid_0,
    input  logic [ID_W-1:0]   req_id_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [LEN_W-1:0]  req_len_0,
    input  logic [1:0]        req_size_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    output logic              req_done_0,
    output logic [RESP_W-1:0] req_resp_0,

    input  logic              req_valid_1,
    input  logic [ID_W-1:0]   req_id_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [LEN_W-1:0]  req_len_1,
    input  logic [1:0]        req_size_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              req_done_1,
    output logic [RESP_W-1:0] req_resp_1,

    output logic              m_aw_valid,
    output logic [ID_W-1:0]   m_id,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LEN_W-1:0]  m_len,
    output logic [1:0]        m_size,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_aw_ready,
    input  logic [RESP_W-1:0] m_w_resp,

    output logic              grant,
    output logic              busy,
    output logic              tmo_err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int             CNT_W  = $clog2(TMO + 1);
    localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TMO);
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TMO - 1);

    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [RESP_W-1:0] resp0_q, resp0_d, resp1_q, resp1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic              active;

    assign active = (state_q == S_ISSUE) || (state_q == S_WAIT);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        resp0_d = resp0_q;
        resp1_d = resp1_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (m_aw_ready && (req_valid_0 || req_valid_1)) begin
                    // On a tie the requester that did not win last time goes first.
                    grant_d = (req_valid_0 && req_valid_1) ? ~last_q : req_valid_1;
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                end
            end
            S_ISSUE: begin
                if (!m_aw_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (m_aw_ready) begin
                    state_d = S_DONE;
                    if (grant_q) resp1_d = m_w_resp;
                    else         resp0_d = m_w_resp;
                end
            end
            default: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
        endcase
        // Watchdog only flags a stuck engine; the transaction keeps waiting.
        if (active) begin
            if (cnt_q != TMO_C)  cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q >= TMO_M1) tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            resp0_q <= '0;
            resp1_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            resp0_q <= resp0_d;
            resp1_q <= resp1_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign m_aw_valid = (state_q == S_ISSUE);
    assign m_id       = !active ? '0 : (grant_q ? req_id_1    : req_id_0);
    assign m_addr     = !active ? '0 : (grant_q ? req_addr_1  : req_addr_0);
    assign m_len      = !active ? '0 : (grant_q ? req_len_1   : req_len_0);
    assign m_size     = !active ? '0 : (grant_q ? req_size_1  : req_size_0);
    assign m_wdata    = !active ? '0 : (grant_q ? req_wdata_1 : req_wdata_0);

    assign req_done_0 = (state_q == S_DONE) && !grant_q;
    assign req_done_1 = (state_q == S_DONE) &&  grant_q;
    assign req_resp_0 = resp0_q;
    assign req_resp_1 = resp1_q;

    assign grant   = grant_q;
    assign busy    = (state_q != S_IDLE);
    assign tmo_err = tmo_q;
endmodule

// File: tb/tb_ysyx_22041071_axi_w_arb.sv
// Directed bench for the two-requester AXI write arbiter (TMO shortened to 16).
module tb_ysyx_22041071_axi_w_arb;
    localparam int ID_W = 4, ADDR_W = 64, LEN_W = 8, DATA_W = 64, RESP_W = 2, TMO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              valid0, valid1, done0, done1;
    logic [ID_W-1:0]   id0, id1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [LEN_W-1:0]  len0, len1;
    logic [1:0]        size0, size1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [RESP_W-1:0] resp0, resp1;
    logic              m_aw_valid, m_aw_ready;
    logic [ID_W-1:0]   m_id;
    logic [ADDR_W-1:0] m_addr;
    logic [LEN_W-1:0]  m_len;
    logic [1:0]        m_size;
    logic [DATA_W-1:0] m_wdata;
    logic [RESP_W-1:0] m_w_resp;
    logic              grant, busy, tmo_err;

    int checks = 0;
    int errors = 0;

    ysyx_22041071_axi_w_arb #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W),
        .RESP_W(RESP_W), .TMO(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid_0(valid0), .req_id_0(id0), .req_addr_0(addr0), .req_len_0(len0),
        .req_size_0(size0), .req_wdata_0(wdata0), .req_done_0(done0), .req_resp_0(resp0),
        .req_valid_1(valid1), .req_id_1(id1), .req_addr_1(addr1), .req_len_1(len1),
        .req_size_1(size1), .req_wdata_1(wdata1), .req_done_1(done1), .req_resp_1(resp1),
        .m_aw_valid(m_aw_valid), .m_id(m_id), .m_addr(m_addr), .m_len(m_len),
        .m_size(m_size), .m_wdata(m_wdata), .m_aw_ready(m_aw_ready), .m_w_resp(m_w_resp),
        .grant(grant), .busy(busy), .tmo_err(tmo_err)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        valid0 = 1'b1; valid1 = 1'b1; m_aw_ready = 1'b1; m_w_resp = 2'b11;
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, m_aw_valid, grant, done0, done1, tmo_err} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {busy, m_aw_valid, grant, done0, done1, tmo_err});
        checks++;
        if (m_id !== '0 || m_addr !== '0 || m_len !== '0 || m_size !== '0 || m_wdata !== '0) begin
            errors++;
            $display("FAIL reset_mfields: got id=%h addr=%h len=%h size=%h expected all 0",
                     m_id, m_addr, m_len, m_size);
        end
        if ({busy, m_aw_valid, grant, done0, done1, tmo_err} !== 6'b0) errors++;
        checks++;
        if (resp0 !== 2'b00 || resp1 !== 2'b00) begin
            errors++;
            $display("FAIL reset_resp: got %b/%b expected 00/00", resp0, resp1);
        end
        valid0 = 1'b0; valid1 = 1'b0; m_w_resp = 2'b00;
        reset_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_single;
        int awv_cnt, d0_cnt, d1_cnt, done_at;
        awv_cnt = 0; d0_cnt = 0; d1_cnt = 0; done_at = -1;
        valid0 = 1'b1; m_w_resp = 2'b00;
        for (int i = 0; i < 14; i++) begin
            m_aw_ready = (i < 2 || i >= 8);
            tick();
            if (m_aw_valid) awv_cnt++;
            if (done1) d1_cnt++;
            if (i < 8) begin
                checks++;
                if (m_addr !== 64'h8000_0010 || m_size !== 2'b10 || m_id !== id0) begin
                    errors++;
                    $display("FAIL single_fields c%0d: got addr=%h size=%b id=%h expected 8000_0010/10/%h",
                             i, m_addr, m_size, m_id, id0);
                end
            end
            if (done0) begin
                d0_cnt++;
                done_at = i;
                checks++;
                if (resp0 !== 2'b00) begin
                    errors++;
                    $display("FAIL single_resp: got %b expected 00", resp0);
                end
                valid0 = 1'b0;
            end
        end
        checks++;
        if (awv_cnt != 2) begin
            errors++;
            $display("FAIL single_awvalid_cycles: got %0d expected 2", awv_cnt);
        end
        checks++;
        if (d0_cnt != 1 || done_at != 8) begin
            errors++;
            $display("FAIL single_done0: got %0d pulses at c%0d expected 1 at c8", d0_cnt, done_at);
        end
        checks++;
        if (d1_cnt != 0) begin
            errors++;
            $display("FAIL single_done1: got %0d pulses expected 0", d1_cnt);
        end
    endtask

    task automatic test_round_robin;
        int exp_order[4] = '{0, 1, 0, 1};
        int ntx, low;
        logic [ID_W-1:0] last_id;
        ntx = 0; low = 0; last_id = '0;
        do_reset();
        valid0 = 1'b1; valid1 = 1'b1; m_aw_ready = 1'b1; m_w_resp = 2'b00;
        for (int i = 0; i < 80 && ntx < 4; i++) begin
            tick();
            if (m_aw_valid) begin
                last_id = m_id;
                m_aw_ready = 1'b0;
                low = 2;
            end else if (!m_aw_ready) begin
                low--;
                if (low == 0) m_aw_ready = 1'b1;
            end
            if (done0 || done1) begin
                checks++;
                if (int'(done1) != exp_order[ntx]) begin
                    errors++;
                    $display("FAIL rr_order tx%0d: got req%0d expected req%0d", ntx, int'(done1), exp_order[ntx]);
                end
                checks++;
                if (last_id !== (done1 ? id1 : id0)) begin
                    errors++;
                    $display("FAIL rr_id tx%0d: got %h expected %h", ntx, last_id, done1 ? id1 : id0);
                end
                ntx++;
            end
        end
        checks++;
        if (ntx != 4) begin
            errors++;
            $display("FAIL rr_count: got %0d transactions expected 4", ntx);
        end
        valid0 = 1'b0; valid1 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_wait_ignore;
        do_reset();
        valid0 = 1'b1; m_aw_ready = 1'b1;
        tick();
        m_aw_ready = 1'b0;
        tick();
        valid1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (m_id !== id0 || m_addr !== addr0 || m_wdata !== wdata0 || grant !== 1'b0 ||
                m_aw_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL wait_hold c%0d: got id=%h addr=%h grant=%b awv=%b expected %h/%h/0/0",
                         i, m_id, m_addr, grant, m_aw_valid, id0, addr0);
            end
        end
        m_aw_ready = 1'b1;
        tick();
        checks++;
        if (done0 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL wait_done0: got %b%b expected 10", done0, done1);
        end
        valid0 = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_gap_idle: got busy=%b expected 0", busy);
        end
        tick();
        checks++;
        if (grant !== 1'b1 || m_aw_valid !== 1'b1 || m_id !== id1 || m_addr !== addr1) begin
            errors++;
            $display("FAIL wait_next_grant: got grant=%b awv=%b id=%h expected 1/1/%h",
                     grant, m_aw_valid, m_id, id1);
        end
        m_aw_ready = 1'b0;
        tick();
        m_aw_ready = 1'b1;
        tick();
        checks++;
        if (done1 !== 1'b1 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL wait_done1: got %b%b expected 01", done0, done1);
        end
        valid1 = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        int bc, tmo_first;
        logic dseen;
        bc = 0; tmo_first = -1; dseen = 1'b0;
        do_reset();
        valid0 = 1'b1; m_aw_ready = 1'b1;
        tick();
        m_aw_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy) bc++;
            if (tmo_err && tmo_first < 0) tmo_first = bc;
            if (done0 || done1) dseen = 1'b1;
            tick();
        end
        checks++;
        if (tmo_first != 17) begin
            errors++;
            $display("FAIL tmo_onset: got first seen in busy cycle %0d expected 17", tmo_first);
        end
        checks++;
        if (busy !== 1'b1 || tmo_err !== 1'b1 || bc != 30) begin
            errors++;
            $display("FAIL tmo_hold: got busy=%b tmo=%b cycles=%0d expected 1/1/30", busy, tmo_err, bc);
        end
        checks++;
        if (dseen !== 1'b0) begin
            errors++;
            $display("FAIL tmo_nodone: got done pulse expected none");
        end
        valid0 = 1'b0;
        do_reset();
        checks++;
        if (tmo_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_reset_clear: got tmo=%b busy=%b expected 0/0", tmo_err, busy);
        end
    endtask

    task automatic test_reset_wait;
        valid1 = 1'b1; m_aw_ready = 1'b1;
        tick();
        m_aw_ready = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || grant !== 1'b1 || m_aw_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstw_pre: got busy=%b grant=%b awv=%b expected 1/1/0", busy, grant, m_aw_valid);
        end
        m_aw_ready = 1'b1;
        reset_n = 1'b0;
        tick();
        checks++;
        if ({busy, m_aw_valid, grant, done0, done1, tmo_err} !== 6'b0 || m_id !== '0 || m_addr !== '0) begin
            errors++;
            $display("FAIL rstw_clear: got %b id=%h addr=%h expected 000000/0/0",
                     {busy, m_aw_valid, grant, done0, done1, tmo_err}, m_id, m_addr);
        end
        valid0 = 1'b1;
        reset_n = 1'b1;
        tick();
        checks++;
        if (grant !== 1'b0 || m_aw_valid !== 1'b1 || m_id !== id0 || done0 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL rstw_tie: got grant=%b awv=%b id=%h expected 0/1/%h", grant, m_aw_valid, m_id, id0);
        end
        valid0 = 1'b0; valid1 = 1'b0;
        do_reset();
    endtask

    task automatic test_slverr;
        do_reset();
        m_w_resp = 2'b01; valid0 = 1'b1; m_aw_ready = 1'b1;
        tick();
        m_aw_ready = 1'b0;
        tick();
        m_aw_ready = 1'b1;
        tick();
        checks++;
        if (done0 !== 1'b1 || resp0 !== 2'b01) begin
            errors++;
            $display("FAIL slv_first: got done0=%b resp0=%b expected 1/01", done0, resp0);
        end
        valid0 = 1'b0;
        tick();
        m_w_resp = 2'b10; valid1 = 1'b1;
        tick();
        m_aw_ready = 1'b0;
        tick();
        m_aw_ready = 1'b1;
        tick();
        checks++;
        if (done1 !== 1'b1 || done0 !== 1'b0 || resp1 !== 2'b10) begin
            errors++;
            $display("FAIL slv_done1: got done=%b%b resp1=%b expected 01/10", done0, done1, resp1);
        end
        checks++;
        if (resp0 !== 2'b01) begin
            errors++;
            $display("FAIL slv_resp0_kept: got %b expected 01", resp0);
        end
        valid1 = 1'b0; m_w_resp = 2'b00;
        tick();
        checks++;
        if (resp1 !== 2'b10 || resp0 !== 2'b01 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL slv_hold: got resp1=%b resp0=%b done1=%b expected 10/01/0", resp1, resp0, done1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; valid0 = 1'b0; valid1 = 1'b0; m_aw_ready = 1'b0; m_w_resp = '0;
        id0 = 4'h3; addr0 = 64'h8000_0010; len0 = 8'h00; size0 = 2'b10; wdata0 = 64'h1111_2222_3333_4444;
        id1 = 4'hA; addr1 = 64'h8000_2000; len1 = 8'h03; size1 = 2'b11; wdata1 = 64'h5555_6666_7777_8888;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_wait_ignore();
        test_timeout();
        test_reset_wait();
        test_slverr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
